// File: rtl/id_scoreboard.sv
// Issue-stage register scoreboard: per-register pending-write flag and latency countdown
// producing RAW/WAW stall, issue and IF-write controls. Optional macro: SCOREBOARD_BYPASS_EN.
module id_scoreboard #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int LW   = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            issue_valid,
  input  logic [AW-1:0]   rs1Addr_id,
  input  logic [AW-1:0]   rs2Addr_id,
  input  logic            rs1_used,
  input  logic            rs2_used,
  input  logic [AW-1:0]   rdAddr_id,
  input  logic            rd_we,
  input  logic [LW-1:0]   lat,
  input  logic            hold,
  input  logic            flush,
  output logic            Stall,
  output logic            IFWrite,
  output logic            issue_fire,
  output logic [NREG-1:0] busy_vec
);

  logic [NREG-1:0]         busy_q, busy_d;
  logic [NREG-1:0][LW-1:0] cnt_q, cnt_d;

  logic [LW-1:0] lat_eff;
  logic          rs1_pend, rs2_pend;
  logic          raw1, raw2, waw;
  logic          wr_en;

  assign lat_eff = (lat == '0) ? LW'(1) : lat;

`ifdef SCOREBOARD_BYPASS_EN
  // A producer with one cycle left reaches the forwarding path in time.
  assign rs1_pend = cnt_q[rs1Addr_id] > LW'(1);
  assign rs2_pend = cnt_q[rs2Addr_id] > LW'(1);
`else
  assign rs1_pend = 1'b1;
  assign rs2_pend = 1'b1;
`endif

  assign raw1 = rs1_used && (rs1Addr_id != '0) && busy_q[rs1Addr_id] && rs1_pend;
  assign raw2 = rs2_used && (rs2Addr_id != '0) && busy_q[rs2Addr_id] && rs2_pend;
  // The new write must land strictly after the one still in flight.
  assign waw  = rd_we && (rdAddr_id != '0) && busy_q[rdAddr_id] && (cnt_q[rdAddr_id] >= lat_eff);

  assign Stall      = issue_valid && !flush && (raw1 || raw2 || waw);
  assign issue_fire = issue_valid && !flush && !Stall && !hold;
  assign IFWrite    = !Stall && !hold;
  assign wr_en      = issue_fire && rd_we && (rdAddr_id != '0);
  assign busy_vec   = busy_q;

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    if (!hold) begin
      for (int r = 1; r < NREG; r++) begin
        if (wr_en && (rdAddr_id == AW'(r))) begin
          busy_d[r] = 1'b1;
          cnt_d[r]  = lat_eff;
        end else if (busy_q[r]) begin
          cnt_d[r] = cnt_q[r] - LW'(1);
          if (cnt_q[r] == LW'(1)) begin
            busy_d[r] = 1'b0;
          end
        end
      end
    end
    busy_d[0] = 1'b0;
    cnt_d[0]  = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_id_scoreboard.sv
// Directed bench for id_scoreboard: driver queues hand-computed expectations, a negedge
// monitor pops and compares them against the DUT outputs.
module tb_id_scoreboard;

`ifdef SCOREBOARD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        issue_valid;
  logic [4:0]  rs1Addr_id, rs2Addr_id, rdAddr_id;
  logic        rs1_used, rs2_used, rd_we;
  logic [2:0]  lat;
  logic        hold, flush;
  logic        Stall, IFWrite, issue_fire;
  logic [31:0] busy_vec;

  typedef struct {
    string       nm;
    logic        s;
    logic        i;
    logic        f;
    logic [31:0] b;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  id_scoreboard #(.NREG(32), .AW(5), .LW(3)) dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid),
    .rs1Addr_id(rs1Addr_id), .rs2Addr_id(rs2Addr_id),
    .rs1_used(rs1_used), .rs2_used(rs2_used),
    .rdAddr_id(rdAddr_id), .rd_we(rd_we), .lat(lat),
    .hold(hold), .flush(flush),
    .Stall(Stall), .IFWrite(IFWrite), .issue_fire(issue_fire),
    .busy_vec(busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.nm, "Stall",      {31'd0, Stall},      {31'd0, e.s});
      chk(e.nm, "IFWrite",    {31'd0, IFWrite},    {31'd0, e.i});
      chk(e.nm, "issue_fire", {31'd0, issue_fire}, {31'd0, e.f});
      chk(e.nm, "busy_vec",   busy_vec,            e.b);
    end
  end

  // One cycle: drive inputs just after the rising edge, queue what the monitor must see.
  task automatic step(input string nm, input logic rst, input logic iv,
                      input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2,
                      input logic [4:0] rd, input logic we, input logic [2:0] lt,
                      input logic hd, input logic fl,
                      input logic es, input logic ei, input logic ef, input logic [31:0] eb);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rst; issue_valid = iv;
    rs1Addr_id = r1; rs1_used = u1; rs2Addr_id = r2; rs2_used = u2;
    rdAddr_id = rd; rd_we = we; lat = lt; hold = hd; flush = fl;
    e.nm = nm; e.s = es; e.i = ei; e.f = ef; e.b = eb;
    exp_q.push_back(e);
  endtask

  initial begin
    rst_n = 1'b0; issue_valid = 1'b0; rs1Addr_id = '0; rs2Addr_id = '0;
    rs1_used = 1'b0; rs2_used = 1'b0; rdAddr_id = '0; rd_we = 1'b0;
    lat = '0; hold = 1'b0; flush = 1'b0;

    //    name        rst iv r1 u1 r2 u2 rd we lat hd fl   S  I  F  busy
    step("rst_hold",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 32'h0);
    step("rst_rel",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 32'h0);
    // RAW on r5, lat 2
    step("raw_iss",   1, 1, 0, 0, 0, 0, 5, 1, 2, 0, 0,   0, 1, 1, 32'h0);
    step("raw_c2",    1, 1, 5, 1, 5, 0, 0, 0, 1, 0, 0,   1, 0, 0, 32'h20);
    step("raw_c1",    1, 1, 5, 1, 5, 0, 0, 0, 1, 0, 0,   !BYP, BYP, BYP, 32'h20);
    step("raw_clr",   1, 1, 5, 1, 0, 0, 0, 0, 1, 0, 0,   0, 1, 1, 32'h0);
    // WAW on r7: load lat 3 then ALU lat 1
    step("waw_iss",   1, 1, 0, 0, 0, 0, 7, 1, 3, 0, 0,   0, 1, 1, 32'h0);
    step("waw_c3",    1, 1, 0, 0, 0, 0, 7, 1, 1, 0, 0,   1, 0, 0, 32'h80);
    step("waw_c2",    1, 1, 0, 0, 0, 0, 7, 1, 1, 0, 0,   1, 0, 0, 32'h80);
    step("waw_c1",    1, 1, 0, 0, 0, 0, 7, 1, 1, 0, 0,   1, 0, 0, 32'h80);
    step("waw_go",    1, 1, 0, 0, 0, 0, 7, 1, 1, 0, 0,   0, 1, 1, 32'h0);
    step("waw_b1",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 32'h80);
    step("waw_b0",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 32'h0);
    // WAW boundary: cnt 1 < new lat 2 issues and overrides the count
    step("wawb_iss",  1, 1, 0, 0, 0, 0, 8, 1, 1, 0, 0,   0, 1, 1, 32'h0);
    step("wawb_ovr",  1, 1, 0, 0, 0, 0, 8, 1, 2, 0, 0,   0, 1, 1, 32'h100);
    step("wawb_c2",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 32'h100);
    step("wawb_c1",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 32'h100);
    step("wawb_clr",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 32'h0);
    // lat 0 behaves as lat 1
    step("lat0_iss",  1, 1, 0, 0, 0, 0, 10, 1, 0, 0, 0,  0, 1, 1, 32'h0);
    step("lat0_b",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 32'h400);
    step("lat0_clr",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 32'h0);
    // hold freezes r3 at cnt 2 and records no issue
    step("hold_iss",  1, 1, 0, 0, 0, 0, 3, 1, 3, 0, 0,   0, 1, 1, 32'h0);
    step("hold_c3",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 32'h8);
    for (int k = 0; k < 4; k++)
      step("hold_frz", 1, 1, 0, 0, 0, 0, 12, 1, 2, 1, 0, 0, 0, 0, 32'h8);
    step("hold_c2",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 32'h8);
    step("hold_c1",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 32'h8);
    step("hold_clr",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 32'h0);
    // register 0 never becomes busy
    step("r0_iss",    1, 1, 0, 0, 0, 0, 0, 1, 4, 0, 0,   0, 1, 1, 32'h0);
    step("r0_read",   1, 1, 0, 1, 0, 1, 0, 0, 1, 0, 0,   0, 1, 1, 32'h0);
    step("r0_idle",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 32'h0);
    // flush masks the hazard; async reset mid-count
    step("fl_iss",    1, 1, 0, 0, 0, 0, 9, 1, 3, 0, 0,   0, 1, 1, 32'h0);
    step("fl_kill",   1, 1, 0, 0, 9, 1, 0, 0, 1, 0, 1,   0, 1, 0, 32'h200);
    step("fl_stall",  1, 1, 0, 0, 9, 1, 0, 0, 1, 0, 0,   1, 0, 0, 32'h200);
    step("arst",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 32'h0);
    step("post_iss",  1, 1, 0, 0, 9, 1, 9, 1, 1, 0, 0,   0, 1, 1, 32'h0);
    step("post_b",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 32'h200);
    step("post_clr",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 32'h0);

    repeat (2) @(posedge clk);
    chk("drain", "pending", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_scoreboard.md
ID_SCOREBOARD -- requirements
Module: id_scoreboard

Interface
REQ-001 Parameter NREG, default 32: architectural register count; register 0 is hard-wired zero.
REQ-002 Parameter AW, default 5: register address width, AW = clog2(NREG).
REQ-003 Parameter LW, default 3: latency field width; legal latency 1..(2^LW - 1).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 issue_valid  input  1  instruction present in ID requesting issue.
REQ-007 rs1Addr_id, rs2Addr_id  input  AW each  source register addresses.
REQ-008 rs1_used, rs2_used  input  1 each  source actually read by the instruction.
REQ-009 rdAddr_id  input  AW  destination register address.
REQ-010 rd_we  input  1  instruction writes rdAddr_id.
REQ-011 lat  input  LW  cycles until result is forwardable (ALU 1, load 2, MUL 3, ...).
REQ-012 hold  input  1  downstream pipeline freeze (memory stall).
REQ-013 flush  input  1  kill instruction currently in ID (taken branch/jump).
REQ-014 Stall  output  1  hazard: instruction in ID must not issue.
REQ-015 IFWrite  output  1  PC/IF-ID register write enable.
REQ-016 issue_fire  output  1  instruction issued this cycle.
REQ-017 busy_vec  output  NREG  per-register pending-write flags (debug/verification).

Function
REQ-018 Per register r (r != 0): busy[r] flag and cnt[r] down-counter of LW bits; busy[0] and cnt[0] SHALL be constant 0.
REQ-019 RAW hazard on source s: s_used & s != 0 & busy[s] & stall condition of REQ-031.
REQ-020 WAW hazard: rd_we & rdAddr_id != 0 & busy[rd] & cnt[rd] >= lat_eff (new write would not complete strictly after the pending one).
REQ-021 lat_eff = lat, except lat = 0 SHALL be treated as 1.
REQ-022 Stall = issue_valid & ~flush & (RAW on rs1 | RAW on rs2 | WAW); combinational, zero latency.
REQ-023 issue_fire = issue_valid & ~flush & ~Stall & ~hold.
REQ-024 IFWrite = ~Stall & ~hold.
REQ-025 Each edge with hold = 0: every busy register decrements cnt by 1; busy clears on the edge where cnt goes 1 -> 0.
REQ-026 Edges with hold = 1: all cnt and busy frozen; no issue recorded.
REQ-027 On issue_fire with rd_we & rdAddr_id != 0: busy[rd] <= 1, cnt[rd] <= lat_eff; this overrides the same-edge decrement/clear of that register.
REQ-028 Issue with rdAddr_id = 0 or rd_we = 0 SHALL NOT change scoreboard state.
REQ-029 flush suppresses only the ID instruction; already-recorded pending writes continue counting down.
REQ-030 busy_vec[r] = busy[r], registered.

Configuration
REQ-031 Macro SCOREBOARD_BYPASS_EN: when defined, RAW stall only if cnt[s] > 1 (cnt = 1 result reaches the forwarding path in time); when undefined, RAW stall whenever busy[s] (no forwarding, wait until clear).
REQ-032 WAW rule (REQ-020) SHALL be identical in both builds.

Reset
REQ-033 rst_n low SHALL immediately, without clock, clear all busy and cnt to 0.
REQ-034 During and after reset with issue_valid = 0, hold = 0: Stall = 0, IFWrite = 1, issue_fire = 0, busy_vec = 0.
REQ-035 Reset asserted mid-countdown SHALL discard all pending entries; first post-reset issue sees an empty scoreboard.

Verification
REQ-036 Reset, issue rd=5 lat=2, next cycle rs1=5 rs1_used=1: bypass build Stall=0 at cnt=1; non-bypass Stall=1 one cycle, busy_vec[5] clears after 2 edges.
REQ-037 Issue rd=7 lat=3 (load), then rd=7 lat=1: Stall=1 (WAW) until cnt[7] < 1... i.e. until busy[7]=0, then issue_fire=1, busy_vec[7]=1 for 1 cycle.
REQ-038 Issue rd=3 lat=3, assert hold 4 cycles: busy_vec[3] stays 1, cnt frozen at 2, IFWrite=0, issue_fire=0; after release clears in 2 edges.
REQ-039 Issue rd=0 lat=4 then read rs1=0: busy_vec=0, Stall=0, issue_fire=1 both cycles.
REQ-040 Stall condition on rs2=9 with flush=1 same cycle: Stall=0, issue_fire=0, IFWrite=1, busy[9] continues countdown; rst_n low mid-count clears busy_vec to 0 asynchronously.
